decoder_onehot_hs: RTL and testbench

Registered binary-to-one-hot decoder with valid/ready handshakes on both sides. Each accepted SEL_W-bit code becomes a one-hot OUT_W-bit word, presented downstream for HOLD_CYCLES consecutive beats. The block is the decode-side counterpart of the team's one-hot-to-binary encoders. It sits between a code producer, such as a register or arbiter grant index, and logic that needs one-hot selects.

---
 rtl/decoder_onehot_hs.sv | 120 ++++++++++++
 tb/tb_decoder_onehot_hs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_onehot_hs.sv
// Purpose: registered binary-to-one-hot decoder with valid/ready on both sides.
// Latency: code accepted at edge k is presented on d_out/d_valid after edge k,
//          held for HOLD_CYCLES beats; throughput one code per HOLD_CYCLES+1 cycles.
// Backpressure: d_ready low freezes d_out/d_valid indefinitely; in_ready is low
//               for the whole OUT phase and depends on state only.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input handshake, in_code = SEL_W-bit binary code
//   in_par            even-parity bit over in_code (DECODER_PARITY_EN only)
//   d_out/d_valid     registered one-hot output word and its valid
//   d_ready           downstream accepts the current beat
//   busy              block is presenting beats
//   dec_cnt           8-bit wrapping count of good codes accepted
//   par_err           one-cycle pulse after a bad-parity code (DECODER_PARITY_EN only)
//
// Optional feature macro: DECODER_PARITY_EN (adds in_par/par_err and parity checking).

module decoder_onehot_hs #(
    parameter int SEL_W       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_code,
`ifdef DECODER_PARITY_EN
    input  logic                     in_par,
    output logic                     par_err,
`endif
    output logic [(1<<SEL_W)-1:0]    d_out,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic                     busy,
    output logic [7:0]               dec_cnt
);

    localparam int OUT_W = 1 << SEL_W;
    // Beat counter holds HOLD_CYCLES-1 down to 0; keep at least one bit.
    localparam int BW    = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(HOLD_CYCLES - 1);

    generate
        if (SEL_W < 1) begin : g_bad_sel_w
            $error("decoder_onehot_hs: SEL_W must be at least 1");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("decoder_onehot_hs: HOLD_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic            code_good;

    // A bad-parity code still completes the input handshake but is dropped.
`ifdef DECODER_PARITY_EN
    assign code_good = ~(^{in_code, in_par});
`else
    assign code_good = 1'b1;
`endif

    // Driven from state only: no path from in_valid or d_ready.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            d_out    <= '0;
            d_valid  <= 1'b0;
            beat_cnt <= '0;
            dec_cnt  <= 8'd0;
`ifdef DECODER_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
`ifdef DECODER_PARITY_EN
            par_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (code_good) begin
                            d_out    <= {{(OUT_W-1){1'b0}}, 1'b1} << in_code;
                            d_valid  <= 1'b1;
                            beat_cnt <= LAST_BEAT;
                            dec_cnt  <= dec_cnt + 8'd1;
                            state    <= OUT;
                        end else begin
`ifdef DECODER_PARITY_EN
                            par_err <= 1'b1;
`endif
                        end
                    end
                end
                OUT: begin
                    // d_valid is always 1 here, so d_ready alone completes a beat.
                    if (d_ready) begin
                        if (beat_cnt != '0) begin
                            beat_cnt <= beat_cnt - BW'(1);
                        end else begin
                            d_valid <= 1'b0;
                            d_out   <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_onehot_hs.sv
// Purpose: directed self-checking bench for decoder_onehot_hs (HOLD_CYCLES=1 and 3).
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: d_ready is driven directly by the directed steps.

module tb_decoder_onehot_hs;

    logic       clk = 1'b0;
    logic       rst;

    // Instance with HOLD_CYCLES = 1
    logic       in_valid1, in_ready1, d_valid1, d_ready1, busy1;
    logic [1:0] in_code1;
    logic [3:0] d_out1;
    logic [7:0] dec_cnt1;

    // Instance with HOLD_CYCLES = 3
    logic       in_valid3, in_ready3, d_valid3, d_ready3, busy3;
    logic [1:0] in_code3;
    logic [3:0] d_out3;
    logic [7:0] dec_cnt3;

`ifdef DECODER_PARITY_EN
    logic       par_flip;
    logic       in_par1, par_err1, in_par3, par_err3;
    // Correct even parity unless par_flip corrupts it.
    assign in_par1 = (^in_code1) ^ par_flip;
    assign in_par3 = ^in_code3;
`endif

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clk = ~clk;

    decoder_onehot_hs #(.SEL_W(2), .HOLD_CYCLES(1)) u1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .in_code  (in_code1),
`ifdef DECODER_PARITY_EN
        .in_par   (in_par1),
        .par_err  (par_err1),
`endif
        .d_out    (d_out1),
        .d_valid  (d_valid1),
        .d_ready  (d_ready1),
        .busy     (busy1),
        .dec_cnt  (dec_cnt1)
    );

    decoder_onehot_hs #(.SEL_W(2), .HOLD_CYCLES(3)) u3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .in_code  (in_code3),
`ifdef DECODER_PARITY_EN
        .in_par   (in_par3),
        .par_err  (par_err3),
`endif
        .d_out    (d_out3),
        .d_valid  (d_valid3),
        .d_ready  (d_ready3),
        .busy     (busy3),
        .dec_cnt  (dec_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid1 = 1'b0; in_code1 = 2'd0; d_ready1 = 1'b1;
        in_valid3 = 1'b0; in_code3 = 2'd0; d_ready3 = 1'b1;
`ifdef DECODER_PARITY_EN
        par_flip  = 1'b0;
`endif

        // Reset state before any clock edge.
        #2;
        check("rst_in_ready", in_ready1, 1);
        check("rst_d_valid",  d_valid1,  0);
        check("rst_d_out",    d_out1,    4'b0000);
        check("rst_dec_cnt",  dec_cnt1,  0);
        check("rst_busy",     busy1,     0);
        check("rst_in_ready3", in_ready3, 1);
`ifdef DECODER_PARITY_EN
        check("rst_par_err",  par_err1,  0);
`endif
        step();
        rst = 1'b0;
        step();

        // Full code sweep, d_ready held high.
        for (int c = 0; c < 4; c++) begin
            in_valid1 = 1'b1;
            in_code1  = 2'(c);
            step();
            in_valid1 = 1'b0;
            check($sformatf("sweep%0d_d_out", c),    d_out1,    exp_oh[c]);
            check($sformatf("sweep%0d_d_valid", c),  d_valid1,  1);
            check($sformatf("sweep%0d_in_ready", c), in_ready1, 0);
            step();
            check($sformatf("sweep%0d_done_valid", c), d_valid1,  0);
            check($sformatf("sweep%0d_done_out", c),   d_out1,    4'b0000);
            check($sformatf("sweep%0d_done_ready", c), in_ready1, 1);
        end
        check("sweep_dec_cnt", dec_cnt1, 4);

        // Backpressure: code 2 held for 5 stalled cycles; in_code changes are ignored.
        d_ready1  = 1'b0;
        in_valid1 = 1'b1;
        in_code1  = 2'd2;
        step();
        in_valid1 = 1'b0;
        in_code1  = 2'd3;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_d_out", i),    d_out1,    4'b0100);
            check($sformatf("bp%0d_d_valid", i),  d_valid1,  1);
            check($sformatf("bp%0d_in_ready", i), in_ready1, 0);
            check($sformatf("bp%0d_busy", i),     busy1,     1);
            step();
        end
        d_ready1 = 1'b1;
        check("bp_last_d_out", d_out1, 4'b0100);
        step();
        check("bp_done_valid", d_valid1,  0);
        check("bp_done_ready", in_ready1, 1);
        check("bp_done_busy",  busy1,     0);
        check("bp_dec_cnt",    dec_cnt1,  5);

        // Wrap: 250 more accepts reach 255, one more wraps to 0.
        for (int i = 0; i < 250; i++) begin
            in_valid1 = 1'b1;
            in_code1  = 2'(i % 4);
            step();
            in_valid1 = 1'b0;
            step();
        end
        check("wrap_255", dec_cnt1, 255);
        in_valid1 = 1'b1;
        in_code1  = 2'd0;
        step();
        in_valid1 = 1'b0;
        step();
        check("wrap_0", dec_cnt1, 0);

        // Reset in the middle of OUT acts without a clock edge.
        d_ready1  = 1'b0;
        in_valid1 = 1'b1;
        in_code1  = 2'd1;
        step();
        in_valid1 = 1'b0;
        check("mid_pre_valid", d_valid1, 1);
        check("mid_pre_cnt",   dec_cnt1, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    d_valid1,  0);
        check("mid_rst_out",      d_out1,    4'b0000);
        check("mid_rst_in_ready", in_ready1, 1);
        check("mid_rst_dec_cnt",  dec_cnt1,  0);
        check("mid_rst_busy",     busy1,     0);
        step();
        rst      = 1'b0;
        d_ready1 = 1'b1;
        in_valid1 = 1'b1;
        in_code1  = 2'd3;
        step();
        in_valid1 = 1'b0;
        check("post_rst_out",   d_out1,   4'b1000);
        check("post_rst_valid", d_valid1, 1);
        check("post_rst_cnt",   dec_cnt1, 1);
        step();
        check("post_rst_done", d_valid1, 0);

        // HOLD_CYCLES=3: three beats of code 1; held in_valid waits for IDLE.
        in_valid3 = 1'b1;
        in_code3  = 2'd1;
        step();
        in_code3  = 2'd2;
        for (int b = 0; b < 3; b++) begin
            check($sformatf("h3_beat%0d_out", b),   d_out3,    4'b0010);
            check($sformatf("h3_beat%0d_valid", b), d_valid3,  1);
            check($sformatf("h3_beat%0d_ready", b), in_ready3, 0);
            step();
        end
        check("h3_idle_valid", d_valid3,  0);
        check("h3_idle_ready", in_ready3, 1);
        check("h3_idle_cnt",   dec_cnt3,  1);
        step();
        in_valid3 = 1'b0;
        check("h3_second_out",   d_out3,   4'b0100);
        check("h3_second_valid", d_valid3, 1);
        check("h3_second_cnt",   dec_cnt3, 2);
        step();
        step();
        check("h3_second_beat3", d_valid3, 1);
        step();
        check("h3_second_done", d_valid3, 0);

`ifdef DECODER_PARITY_EN
        // Bad parity: code 3 with in_par=1.
        in_valid1 = 1'b1;
        in_code1  = 2'd3;
        par_flip  = 1'b1;
        step();
        in_valid1 = 1'b0;
        par_flip  = 1'b0;
        check("par_err_pulse", par_err1,  1);
        check("par_no_valid",  d_valid1,  0);
        check("par_in_ready",  in_ready1, 1);
        check("par_cnt_same",  dec_cnt1,  1);
        step();
        check("par_err_clear", par_err1, 0);
        in_valid1 = 1'b1;
        in_code1  = 2'd3;
        step();
        in_valid1 = 1'b0;
        check("par_good_out", d_out1,   4'b1000);
        check("par_good_cnt", dec_cnt1, 2);
        check("par_good_err", par_err1, 0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
